id_ex_issue_stage: RTL and testbench

ID/EX issue stage directly upstream of the 64-bit ALU. It latches one decoded instruction, forwards operands from EX/MEM and MEM/WB, and holds `a_out`, `b_out` and `alu_op_out` stable for the ALU. Multiply and divide ops are held for a fixed multi-cycle window before `out_valid` is raised. It uses valid/ready handshakes on both sides and supports a pipeline flush.

---
 rtl/legv8_pkg.sv | 19 +
 rtl/operand_forward_unit.sv | 37 +++
 rtl/id_ex_issue_stage.sv | 224 ++++++++++++++++++++++
 tb/tb_id_ex_issue_stage.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared LEGv8 ALU op codes, register constants and issue-stage states
package legv8_pkg;

  localparam logic [2:0] ALU_NOP  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_DIV  = 3'b011;
  localparam logic [2:0] ALU_MUL  = 3'b100;
  localparam logic [2:0] ALU_PASS = 3'b101;

  localparam logic [4:0] REG_XZR = 5'd31;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } issue_state_t;

endpackage

// File: rtl/operand_forward_unit.sv
// rtl/operand_forward_unit.sv - EX/MEM over MEM/WB forwarding mux; XZR reads zero
module operand_forward_unit
  import legv8_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [4:0]        i_addr,
  input  logic [DATA_W-1:0] i_base,
  input  logic              i_exmem_reg_write,
  input  logic [4:0]        i_exmem_rd,
  input  logic [DATA_W-1:0] i_exmem_result,
  input  logic              i_memwb_reg_write,
  input  logic [4:0]        i_memwb_rd,
  input  logic [DATA_W-1:0] i_memwb_result,
  output logic [DATA_W-1:0] o_data
);

  logic w_is_xzr;
  logic w_exmem_hit;
  logic w_memwb_hit;

  assign w_is_xzr    = (i_addr == REG_XZR);
  assign w_exmem_hit = i_exmem_reg_write && (i_exmem_rd == i_addr) && !w_is_xzr;
  assign w_memwb_hit = i_memwb_reg_write && (i_memwb_rd == i_addr) && !w_is_xzr;

  always_comb begin
    o_data = i_base;
    if (w_is_xzr) begin
      o_data = '0;
    end else if (w_exmem_hit) begin
      o_data = i_exmem_result;
    end else if (w_memwb_hit) begin
      o_data = i_memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_issue_stage.sv
// rtl/id_ex_issue_stage.sv - ID/EX issue stage: capture, forwarding, mul/div hold window
// Optional ID_EX_DIV0_GUARD_EN: DIV by zero issues as NOP and raises div0.
module id_ex_issue_stage
  import legv8_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_rn_data,
  input  logic [DATA_W-1:0] in_rm_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic [2:0]        in_alu_op,
  input  logic [4:0]        in_rn_addr,
  input  logic [4:0]        in_rm_addr,
  input  logic [4:0]        in_rd_addr,
  input  logic              in_reg_write,
  input  logic              exmem_reg_write,
  input  logic [4:0]        exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [4:0]        memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [2:0]        alu_op_out,
  output logic [4:0]        rd_out,
  output logic              reg_write_out,
  output logic              busy,
  output logic              div0
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  issue_state_t      r_state;
  issue_state_t      w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [CNT_W-1:0]  w_lat_cnt;

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [2:0]        r_op;
  logic [4:0]        r_rd;
  logic              r_reg_write;
  logic [4:0]        r_rn_addr;
  logic [4:0]        r_rm_addr;
  logic              r_use_imm;

  logic              w_in_ready;
  logic              w_capture;
  logic [4:0]        w_fa_addr;
  logic [DATA_W-1:0] w_fa_base;
  logic [4:0]        w_fb_addr;
  logic [DATA_W-1:0] w_fb_base;
  logic [DATA_W-1:0] w_a_next;
  logic [DATA_W-1:0] w_fb_out;
  logic [DATA_W-1:0] w_b_next;
  logic              w_use_imm;
  logic [2:0]        w_op_next;
  logic [2:0]        w_op_load;

  assign w_in_ready = !reset && !flush && ((r_state == EMPTY) || ((r_state == READY) && out_ready));
  assign w_capture  = in_valid && w_in_ready;

  always_comb begin
    w_lat_cnt = '0;
    case (in_alu_op)
      ALU_MUL: w_lat_cnt = CNT_W'(MUL_LAT - 1);
      ALU_DIV: w_lat_cnt = CNT_W'(DIV_LAT - 1);
      default: w_lat_cnt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (flush) begin
      w_state_next = EMPTY;
      w_cnt_next   = '0;
    end else if (w_capture) begin
      w_cnt_next   = w_lat_cnt;
      w_state_next = (w_lat_cnt == '0) ? READY : WAIT;
    end else begin
      case (r_state)
        WAIT: begin
          if (r_cnt <= CNT_W'(1)) begin
            w_state_next = READY;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt - CNT_W'(1);
          end
        end
        READY: begin
          if (out_ready) begin
            w_state_next = EMPTY;
          end
        end
        default: begin
          w_state_next = r_state;
        end
      endcase
    end
  end

  // The same forwarding units serve capture (fresh operands) and hold (re-apply to held values).
  assign w_fa_addr = w_capture ? in_rn_addr : r_rn_addr;
  assign w_fa_base = w_capture ? in_rn_data : r_a;
  assign w_fb_addr = w_capture ? in_rm_addr : r_rm_addr;
  assign w_fb_base = w_capture ? in_rm_data : r_b;
  assign w_use_imm = w_capture ? in_use_imm : r_use_imm;
  assign w_op_next = w_capture ? in_alu_op : r_op;

  operand_forward_unit #(
    .DATA_W (DATA_W)
  ) u_fwd_a (
    .i_addr            (w_fa_addr),
    .i_base            (w_fa_base),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_result    (memwb_result),
    .o_data            (w_a_next)
  );

  operand_forward_unit #(
    .DATA_W (DATA_W)
  ) u_fwd_b (
    .i_addr            (w_fb_addr),
    .i_base            (w_fb_base),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_result    (memwb_result),
    .o_data            (w_fb_out)
  );

  assign w_b_next = w_use_imm ? (w_capture ? in_imm : r_b) : w_fb_out;

`ifdef ID_EX_DIV0_GUARD_EN
  logic w_enter_ready;
  logic w_div0_hit;
  logic r_div0;

  // Decided once, on the cycle the op becomes visible to the ALU.
  assign w_enter_ready = !flush && (w_state_next == READY) && (w_capture || (r_state == WAIT));
  assign w_div0_hit    = w_enter_ready && (w_op_next == ALU_DIV) && (w_b_next == '0);
  assign w_op_load     = w_div0_hit ? ALU_NOP : w_op_next;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_div0 <= 1'b0;
    end else if (w_capture || w_enter_ready) begin
      r_div0 <= w_div0_hit;
    end
  end

  assign div0 = r_div0;
`else
  assign w_op_load = w_op_next;
  assign div0      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= ALU_NOP;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_rn_addr   <= '0;
      r_rm_addr   <= '0;
      r_use_imm   <= 1'b0;
    end else if (flush) begin
      r_op <= r_op;
    end else if (w_capture) begin
      r_a         <= w_a_next;
      r_b         <= w_b_next;
      r_op        <= w_op_load;
      r_rd        <= in_rd_addr;
      r_reg_write <= in_reg_write;
      r_rn_addr   <= in_rn_addr;
      r_rm_addr   <= in_rm_addr;
      r_use_imm   <= in_use_imm;
    end else if (r_state != EMPTY) begin
      r_a  <= w_a_next;
      r_b  <= w_b_next;
      r_op <= w_op_load;
    end
  end

  assign in_ready      = w_in_ready;
  assign out_valid     = (r_state == READY);
  assign busy          = (r_state == WAIT);
  assign a_out         = r_a;
  assign b_out         = r_b;
  assign alu_op_out    = r_op;
  assign rd_out        = r_rd;
  assign reg_write_out = r_reg_write;

endmodule

// File: tb/tb_id_ex_issue_stage.sv
// tb/tb_id_ex_issue_stage.sv - directed and randomized bench for id_ex_issue_stage
module tb_id_ex_issue_stage;

  localparam int DATA_W  = 64;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 16;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, in_use_imm, in_reg_write;
  logic [DATA_W-1:0] in_rn_data, in_rm_data, in_imm;
  logic [2:0]        in_alu_op;
  logic [4:0]        in_rn_addr, in_rm_addr, in_rd_addr;
  logic              exmem_reg_write, memwb_reg_write, out_ready;
  logic [4:0]        exmem_rd, memwb_rd;
  logic [DATA_W-1:0] exmem_result, memwb_result;
  logic              in_ready, out_valid, reg_write_out, busy, div0;
  logic [DATA_W-1:0] a_out, b_out;
  logic [2:0]        alu_op_out;
  logic [4:0]        rd_out;

  always #5 clk = ~clk;

  id_ex_issue_stage #(
    .DATA_W (DATA_W), .MUL_LAT (MUL_LAT), .DIV_LAT (DIV_LAT)
  ) dut (
    .clk (clk), .reset (reset), .flush (flush),
    .in_valid (in_valid), .in_ready (in_ready),
    .in_rn_data (in_rn_data), .in_rm_data (in_rm_data), .in_imm (in_imm),
    .in_use_imm (in_use_imm), .in_alu_op (in_alu_op),
    .in_rn_addr (in_rn_addr), .in_rm_addr (in_rm_addr), .in_rd_addr (in_rd_addr),
    .in_reg_write (in_reg_write),
    .exmem_reg_write (exmem_reg_write), .exmem_rd (exmem_rd), .exmem_result (exmem_result),
    .memwb_reg_write (memwb_reg_write), .memwb_rd (memwb_rd), .memwb_result (memwb_result),
    .out_valid (out_valid), .out_ready (out_ready),
    .a_out (a_out), .b_out (b_out), .alu_op_out (alu_op_out),
    .rd_out (rd_out), .reg_write_out (reg_write_out), .busy (busy), .div0 (div0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: one held instruction plus cycles left until it is offered.
  bit          m_held = 1'b0;
  int          m_left = 0;
  logic [63:0] m_a, m_b;
  logic [2:0]  m_op;
  logic [4:0]  m_rd, m_rn, m_rm;
  bit          m_rw, m_imm, m_div0;

  function automatic logic [63:0] fwd(input logic [4:0] addr, input logic [63:0] base);
    if (addr == 5'd31) return 64'd0;
    if (exmem_reg_write && exmem_rd == addr) return exmem_result;
    if (memwb_reg_write && memwb_rd == addr) return memwb_result;
    return base;
  endfunction

  function automatic int lat_of(input logic [2:0] op);
    if (op == 3'b100) return MUL_LAT;
    if (op == 3'b011) return DIV_LAT;
    return 1;
  endfunction

  function automatic bit m_valid();
    return m_held && (m_left == 0);
  endfunction

  function automatic bit exp_in_ready();
    return !reset && !flush && (!m_held || (m_valid() && out_ready));
  endfunction

  task automatic guard_on_offer();
`ifdef ID_EX_DIV0_GUARD_EN
    if (m_op == 3'b011 && m_b == 64'd0) begin
      m_op   = 3'b000;
      m_div0 = 1'b1;
    end
`endif
  endtask

  task automatic model_edge();
    bit rdy;
    rdy = exp_in_ready();
    if (reset) begin
      m_held = 0; m_left = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_rw = 0; m_div0 = 0;
    end else if (flush) begin
      m_held = 0; m_left = 0; m_div0 = 0;
    end else if (in_valid && rdy) begin
      m_a    = fwd(in_rn_addr, in_rn_data);
      m_b    = in_use_imm ? in_imm : fwd(in_rm_addr, in_rm_data);
      m_op   = in_alu_op;  m_rd = in_rd_addr; m_rw = in_reg_write;
      m_rn   = in_rn_addr; m_rm = in_rm_addr; m_imm = in_use_imm;
      m_div0 = 0;
      m_held = 1;
      m_left = lat_of(in_alu_op) - 1;
      if (m_left == 0) guard_on_offer();
    end else if (m_held) begin
      m_a = fwd(m_rn, m_a);
      if (!m_imm) m_b = fwd(m_rm, m_b);
      if (m_valid()) begin
        if (out_ready) m_held = 0;
      end else begin
        m_left--;
        if (m_left == 0) guard_on_offer();
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("out_valid", out_valid, m_valid());
    check_eq("busy", busy, m_held && m_left > 0);
    if (m_valid()) begin
      check_eq("a_out", a_out, m_a);
      check_eq("b_out", b_out, m_b);
      check_eq("alu_op_out", alu_op_out, m_op);
      check_eq("rd_out", rd_out, m_rd);
      check_eq("reg_write_out", reg_write_out, m_rw);
      check_eq("div0", div0, m_div0);
    end
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic step();
    #1;
    check_eq("in_ready", in_ready, exp_in_ready());
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    reset = 0; flush = 0; in_valid = 0; in_use_imm = 0; in_reg_write = 0;
    in_rn_data = 0; in_rm_data = 0; in_imm = 0; in_alu_op = 0;
    in_rn_addr = 0; in_rm_addr = 0; in_rd_addr = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    out_ready = 1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] rn, input logic [63:0] rn_d,
                       input logic [4:0] rm, input logic [63:0] rm_d);
    in_valid = 1; in_alu_op = op; in_rn_addr = rn; in_rn_data = rn_d;
    in_rm_addr = rm; in_rm_data = rm_d; in_use_imm = 0; in_rd_addr = 5'd9; in_reg_write = 1;
  endtask

  function automatic logic [4:0] rand_reg();
    logic [4:0] pool [5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd31};
    if ($urandom_range(0, 9) < 7) return pool[$urandom_range(0, 4)];
    return 5'($urandom_range(0, 31));
  endfunction

  function automatic logic [63:0] rand_data();
    if ($urandom_range(0, 9) == 0) return 64'd0;
    return {$urandom, $urandom};
  endfunction

  function automatic logic [2:0] rand_op();
    int r;
    logic [2:0] simple [4] = '{3'b000, 3'b001, 3'b010, 3'b101};
    r = $urandom_range(0, 19);
    if (r < 2) return 3'b011;
    if (r < 5) return 3'b100;
    return simple[$urandom_range(0, 3)];
  endfunction

  initial begin
    bit seen;
    bit any_valid;
    idle_inputs();
    @(negedge clk);

    reset = 1; in_valid = 1; in_alu_op = 3'b010; in_rn_data = 64'hdead;
    step();
    step();
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_a_out", a_out, 0);
    check_eq("rst_b_out", b_out, 0);
    check_eq("rst_alu_op", alu_op_out, 0);
    check_eq("rst_rd_out", rd_out, 0);
    check_eq("rst_reg_write", reg_write_out, 0);
    check_eq("rst_div0", div0, 0);
    idle_inputs();
    #1;
    check_eq("post_rst_in_ready", in_ready, 1);

    issue(3'b010, 5'd1, 64'd5, 5'd2, 64'd7);
    step();
    check_eq("add_a", a_out, 5);
    check_eq("add_b", b_out, 7);
    check_eq("add_op", alu_op_out, 3'b010);
    check_eq("add_valid", out_valid, 1);
    idle_inputs();

    issue(3'b001, 5'd1, 64'd1, 5'd2, 64'd2);
    exmem_reg_write = 1; exmem_rd = 5'd1; exmem_result = 64'd100;
    memwb_reg_write = 1; memwb_rd = 5'd1; memwb_result = 64'd50;
    step();
    check_eq("sub_exmem_prio", a_out, 100);
    idle_inputs();

    issue(3'b010, 5'd31, 64'd77, 5'd2, 64'd1);
    exmem_reg_write = 1; exmem_rd = 5'd31; exmem_result = 64'd9;
    step();
    check_eq("xzr_a", a_out, 0);
    idle_inputs();
    step();

    issue(3'b100, 5'd1, 64'd6, 5'd2, 64'd7);
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      check_eq("mul_busy", busy, 1);
      check_eq("mul_in_ready", in_ready, 0);
      check_eq("mul_not_valid", out_valid, 0);
      step();
    end
    check_eq("mul_valid_4th", out_valid, 1);
    step();

    issue(3'b011, 5'd1, 64'd20, 5'd4, 64'd0);
    step();
    idle_inputs();
    seen = 0;
    for (int i = 0; i < DIV_LAT + 4 && !seen; i++) begin
      memwb_reg_write = (i == 3); memwb_rd = 5'd4; memwb_result = 64'd3;
      step();
      if (out_valid) begin
        seen = 1;
        check_eq("div_fwd_b", b_out, 3);
      end
    end
    check_eq("div_valid_seen", seen, 1);
    idle_inputs();
    step();

    issue(3'b011, 5'd1, 64'd20, 5'd2, 64'd4);
    step();
    idle_inputs();
    step();
    flush = 1;
    step();
    check_eq("flush_empty_busy", busy, 0);
    check_eq("flush_empty_valid", out_valid, 0);
    flush = 0;
    any_valid = 0;
    for (int i = 0; i < DIV_LAT + 4; i++) begin
      step();
      any_valid |= out_valid;
    end
    check_eq("flush_never_valid", any_valid, 0);

    issue(3'b011, 5'd1, 64'd20, 5'd2, 64'd0);
    step();
    idle_inputs();
    seen = 0;
    for (int i = 0; i < DIV_LAT + 4 && !seen; i++) begin
      step();
      if (out_valid) begin
        seen = 1;
`ifdef ID_EX_DIV0_GUARD_EN
        check_eq("div0_op", alu_op_out, 3'b000);
        check_eq("div0_flag", div0, 1);
`else
        check_eq("div0_op", alu_op_out, 3'b011);
        check_eq("div0_flag", div0, 0);
`endif
      end
    end
    check_eq("div0_valid_seen", seen, 1);
    step();

    for (int i = 0; i < 4; i++) begin
      issue(3'b010, 5'd3, 64'(100 + i), 5'd2, 64'd1);
      step();
      check_eq("b2b_valid", out_valid, 1);
      check_eq("b2b_a", a_out, 100 + i);
    end
    idle_inputs();
    step();

    for (int i = 0; i < 600; i++) begin
      flush           = ($urandom_range(0, 39) == 0);
      in_valid        = ($urandom_range(0, 9) < 7);
      in_alu_op       = rand_op();
      in_rn_addr      = rand_reg();
      in_rm_addr      = rand_reg();
      in_rd_addr      = rand_reg();
      in_reg_write    = 1'($urandom_range(0, 1));
      in_rn_data      = rand_data();
      in_rm_data      = rand_data();
      in_imm          = rand_data();
      in_use_imm      = ($urandom_range(0, 3) == 0);
      exmem_reg_write = 1'($urandom_range(0, 1));
      exmem_rd        = rand_reg();
      exmem_result    = rand_data();
      memwb_reg_write = 1'($urandom_range(0, 1));
      memwb_rd        = rand_reg();
      memwb_result    = rand_data();
      out_ready       = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
